hex_display_ctrl: RTL and testbench

- Parametrised, registered multi-digit hexadecimal display controller for the 7-segment HEX displays.
- Latches an N-nibble value on a load strobe and decodes each nibble to an active-low glyph.
- Adds optional leading-zero blanking and per-digit blinking.
- Provides a time-multiplexed scan output for common-segment displays alongside the parallel per-digit outputs.

---
 rtl/hex_display_pkg.sv | 21 ++
 rtl/hex7seg_glyph.sv | 15 +
 rtl/hex_display_ctrl.sv | 150 +++++++++++++++
 tb/tb_hex_display_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/hex_display_pkg.sv
// rtl/hex_display_pkg.sv - shared types and glyph table for the hex display controller
//
// Provides:
//   seg7_t       7-bit active-low segment pattern, bit0 = segment a .. bit6 = segment g
//   GLYPH_BLANK  all segments off
//   GLYPH_TABLE  active-low glyphs for hex digits 0..F, indexed by nibble value
package hex_display_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t GLYPH_BLANK = 7'h7F;

    // Packed so a variable nibble index selects one entry; entry 0 sits in the LSBs.
    localparam logic [15:0][6:0] GLYPH_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

endpackage

// File: rtl/hex7seg_glyph.sv
// rtl/hex7seg_glyph.sv - combinational hex nibble to active-low 7-segment glyph decoder
//
// Ports:
//   nibble  in   4  hex digit value
//   glyph   out  7  active-low segment pattern for that digit
module hex7seg_glyph
    import hex_display_pkg::*;
(
    input  logic [3:0] nibble,
    output seg7_t      glyph
);

    assign glyph = GLYPH_TABLE[nibble];

endmodule

// File: rtl/hex_display_ctrl.sv
// rtl/hex_display_ctrl.sv - registered multi-digit hex display with blanking, blink and scan output
//
// Ports:
//   CLOCK_50    in   1             system clock, rising edge
//   resetn      in   1             asynchronous active-low reset
//   load        in   1             capture value on this edge
//   value       in   4*NUM_DIGITS  hex digits, digit 0 in value[3:0]
//   blank_lz    in   1             leading-zero blanking enable
//   blink_en    in   1             blink enable
//   blink_mask  in   NUM_DIGITS    per-digit blink select
//   scan_mode   in   1             1 = drive the multiplexed SEG/DIG_SEL outputs
//   HEX_ALL     out  7*NUM_DIGITS  registered active-low glyphs, digit i in [7i+6:7i]
//   SEG         out  7             registered glyph of the scanned digit
//   DIG_SEL     out  NUM_DIGITS    registered active-low one-hot digit select
module hex_display_ctrl
    import hex_display_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int BLINK_DIV  = 25000000,
    parameter int SCAN_DIV   = 50000
) (
    input  logic                    CLOCK_50,
    input  logic                    resetn,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    blank_lz,
    input  logic                    blink_en,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic                    scan_mode,
    output logic [7*NUM_DIGITS-1:0] HEX_ALL,
    output logic [6:0]              SEG,
    output logic [NUM_DIGITS-1:0]   DIG_SEL
);

    localparam int BW = $clog2(BLINK_DIV);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(NUM_DIGITS);

    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    logic [4*NUM_DIGITS-1:0] value_q;
    logic [BW-1:0]           blink_cnt;
    logic                    blink_phase;
    logic [SW-1:0]           scan_cnt;
    logic [IW-1:0]           scan_idx;

    seg7_t                   raw_glyph   [NUM_DIGITS];
    seg7_t                   final_glyph [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   lz_blank;
    logic                    zero_above;
    logic                    blink_on;
    logic [7*NUM_DIGITS-1:0] hex_next;

    logic [BW-1:0]           blink_cnt_next;
    logic                    blink_phase_next;
    logic                    scan_tick;
    logic [SW-1:0]           scan_cnt_next;
    logic [IW-1:0]           scan_idx_next;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
        hex7seg_glyph u_glyph (
            .nibble (value_q[4*g +: 4]),
            .glyph  (raw_glyph[g])
        );
    end

    // Walk from the MSB down; a digit is a leading zero while it and every
    // digit above it are zero. Digit 0 always stays visible.
    always_comb begin
        lz_blank   = '0;
        zero_above = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            lz_blank[i] = blank_lz && zero_above && (value_q[4*i +: 4] == 4'd0) && (i != 0);
            zero_above  = zero_above && (value_q[4*i +: 4] == 4'd0);
        end
    end

    // Gate the phase with blink_en so dropping the enable un-blanks on the very next edge.
    assign blink_on = blink_en & blink_phase;

    always_comb begin
        hex_next = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            final_glyph[i] = (lz_blank[i] || (blink_on && blink_mask[i])) ? GLYPH_BLANK : raw_glyph[i];
            hex_next[7*i +: 7] = final_glyph[i];
        end
    end

    always_comb begin
        blink_cnt_next   = '0;
        blink_phase_next = 1'b0;
        if (blink_en) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt_next   = '0;
                blink_phase_next = ~blink_phase;
            end else begin
                blink_cnt_next   = blink_cnt + BW'(1);
                blink_phase_next = blink_phase;
            end
        end
    end

    always_comb begin
        scan_tick     = scan_mode && (scan_cnt == SCAN_LAST);
        scan_cnt_next = '0;
        scan_idx_next = '0;
        if (scan_mode) begin
            scan_cnt_next = scan_tick ? '0 : scan_cnt + SW'(1);
            if (scan_tick) begin
                scan_idx_next = (scan_idx == IDX_LAST) ? '0 : scan_idx + IW'(1);
            end else begin
                scan_idx_next = scan_idx;
            end
        end
    end

    // SEG/DIG_SEL are built from the next index so they change on the same
    // edge as scan_idx itself.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            value_q     <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            scan_cnt    <= '0;
            scan_idx    <= '0;
            HEX_ALL     <= '1;
            SEG         <= GLYPH_BLANK;
            DIG_SEL     <= '1;
        end else begin
            if (load) begin
                value_q <= value;
            end
            blink_cnt   <= blink_cnt_next;
            blink_phase <= blink_phase_next;
            scan_cnt    <= scan_cnt_next;
            scan_idx    <= scan_idx_next;
            HEX_ALL     <= hex_next;
            if (scan_mode) begin
                SEG     <= final_glyph[scan_idx_next];
                DIG_SEL <= ~(NUM_DIGITS'(1) << scan_idx_next);
            end else begin
                SEG     <= GLYPH_BLANK;
                DIG_SEL <= '1;
            end
        end
    end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// tb/tb_hex_display_ctrl.sv - directed self-checking bench for hex_display_ctrl
module tb_hex_display_ctrl;

    logic        clk;
    logic        resetn;
    logic        load;
    logic [15:0] value;
    logic        blank_lz;
    logic        blink_en;
    logic [3:0]  blink_mask;
    logic        scan_mode;
    logic [27:0] hex_all;
    logic [6:0]  seg;
    logic [3:0]  dig_sel;

    int errors = 0;
    int checks = 0;

    hex_display_ctrl #(
        .NUM_DIGITS (4),
        .BLINK_DIV  (4),
        .SCAN_DIV   (3)
    ) dut (
        .CLOCK_50   (clk),
        .resetn     (resetn),
        .load       (load),
        .value      (value),
        .blank_lz   (blank_lz),
        .blink_en   (blink_en),
        .blink_mask (blink_mask),
        .scan_mode  (scan_mode),
        .HEX_ALL    (hex_all),
        .SEG        (seg),
        .DIG_SEL    (dig_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge; inputs change and outputs are sampled 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0; load = 1'b0; value = '0; blank_lz = 1'b0;
        blink_en = 1'b0; blink_mask = '0; scan_mode = 1'b0;
        step(); step();
        checks++;
        if (hex_all !== {28{1'b1}}) begin
            errors++; $display("FAIL reset_hex_all got=%h exp=%h", hex_all, {28{1'b1}});
        end
        checks++;
        if (seg !== 7'h7F || dig_sel !== 4'b1111) begin
            errors++; $display("FAIL reset_scan_out got seg=%h dig=%b exp seg=7f dig=1111", seg, dig_sel);
        end
        resetn = 1'b1;
        step();
        checks++;
        if (hex_all !== {7'h40, 7'h40, 7'h40, 7'h40}) begin
            errors++; $display("FAIL release_hex_all got=%h exp=%h", hex_all, {7'h40, 7'h40, 7'h40, 7'h40});
        end
    endtask

    task automatic test_load();
        value = 16'h00A5; load = 1'b1; blank_lz = 1'b0;
        step();
        load = 1'b0;
        checks++;
        if (hex_all !== {7'h40, 7'h40, 7'h40, 7'h40}) begin
            errors++; $display("FAIL load_latency got=%h exp=%h", hex_all, {7'h40, 7'h40, 7'h40, 7'h40});
        end
        step();
        checks++;
        if (hex_all !== {7'h40, 7'h40, 7'h08, 7'h12}) begin
            errors++; $display("FAIL load_00a5 got=%h exp=%h", hex_all, {7'h40, 7'h40, 7'h08, 7'h12});
        end
        blank_lz = 1'b1;
        step();
        checks++;
        if (hex_all !== {7'h7F, 7'h7F, 7'h08, 7'h12}) begin
            errors++; $display("FAIL blank_lz_00a5 got=%h exp=%h", hex_all, {7'h7F, 7'h7F, 7'h08, 7'h12});
        end
        value = 16'hFFFF;
        step(); step();
        checks++;
        if (hex_all !== {7'h7F, 7'h7F, 7'h08, 7'h12}) begin
            errors++; $display("FAIL no_load_ignored got=%h exp=%h", hex_all, {7'h7F, 7'h7F, 7'h08, 7'h12});
        end
        value = 16'h0000; load = 1'b1;
        step();
        load = 1'b0;
        step();
        checks++;
        if (hex_all !== {7'h7F, 7'h7F, 7'h7F, 7'h40}) begin
            errors++; $display("FAIL blank_lz_zero got=%h exp=%h", hex_all, {7'h7F, 7'h7F, 7'h7F, 7'h40});
        end
        value = 16'hE00C; load = 1'b1;
        step();
        load = 1'b0;
        step();
        checks++;
        if (hex_all !== {7'h06, 7'h40, 7'h40, 7'h46}) begin
            errors++; $display("FAIL blank_lz_inner_zero got=%h exp=%h", hex_all, {7'h06, 7'h40, 7'h40, 7'h46});
        end
        blank_lz = 1'b0;
    endtask

    task automatic test_blink();
        logic [6:0] d0;
        value = 16'h1234; load = 1'b1;
        step();
        load = 1'b0;
        step();
        blink_en = 1'b1; blink_mask = 4'b0001;
        for (int n = 1; n <= 14; n++) begin
            step();
            d0 = (((n - 1) / 4) % 2 == 1) ? 7'h7F : 7'h19;
            checks++;
            if (hex_all !== {7'h79, 7'h24, 7'h30, d0}) begin
                errors++; $display("FAIL blink_step%0d got=%h exp=%h", n, hex_all, {7'h79, 7'h24, 7'h30, d0});
            end
        end
        blink_en = 1'b0;
        step();
        checks++;
        if (hex_all !== {7'h79, 7'h24, 7'h30, 7'h19}) begin
            errors++; $display("FAIL blink_disable got=%h exp=%h", hex_all, {7'h79, 7'h24, 7'h30, 7'h19});
        end
        blink_mask = 4'b0000;
    endtask

    task automatic test_scan();
        logic [6:0] exp_seg;
        logic [3:0] exp_sel;
        int idx;
        checks++;
        if (seg !== 7'h7F || dig_sel !== 4'b1111) begin
            errors++; $display("FAIL scan_off got seg=%h dig=%b exp seg=7f dig=1111", seg, dig_sel);
        end
        scan_mode = 1'b1;
        for (int n = 1; n <= 18; n++) begin
            step();
            idx = (n / 3) % 4;
            case (idx)
                0: begin exp_seg = 7'h19; exp_sel = 4'b1110; end
                1: begin exp_seg = 7'h30; exp_sel = 4'b1101; end
                2: begin exp_seg = 7'h24; exp_sel = 4'b1011; end
                default: begin exp_seg = 7'h79; exp_sel = 4'b0111; end
            endcase
            checks++;
            if (seg !== exp_seg || dig_sel !== exp_sel) begin
                errors++; $display("FAIL scan_step%0d got seg=%h dig=%b exp seg=%h dig=%b",
                                   n, seg, dig_sel, exp_seg, exp_sel);
            end
        end
        checks++;
        if (hex_all !== {7'h79, 7'h24, 7'h30, 7'h19}) begin
            errors++; $display("FAIL scan_hex_all got=%h exp=%h", hex_all, {7'h79, 7'h24, 7'h30, 7'h19});
        end
    endtask

    task automatic test_reset_mid_scan();
        checks++;
        if (dig_sel !== 4'b1011) begin
            errors++; $display("FAIL pre_reset_sel got=%b exp=1011", dig_sel);
        end
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if (hex_all !== {28{1'b1}} || seg !== 7'h7F || dig_sel !== 4'b1111) begin
            errors++; $display("FAIL async_reset got hex=%h seg=%h dig=%b exp all ones/7f/1111",
                               hex_all, seg, dig_sel);
        end
        step();
        resetn = 1'b1;
        step();
        checks++;
        if (seg !== 7'h40 || dig_sel !== 4'b1110) begin
            errors++; $display("FAIL scan_restart got seg=%h dig=%b exp seg=40 dig=1110", seg, dig_sel);
        end
    endtask

    task automatic test_load_during_scan();
        step();
        value = 16'h1234; load = 1'b1;
        step();
        load = 1'b0;
        checks++;
        if (seg !== 7'h40 || dig_sel !== 4'b1101) begin
            errors++; $display("FAIL load_tick_edge got seg=%h dig=%b exp seg=40 dig=1101", seg, dig_sel);
        end
        step();
        checks++;
        if (seg !== 7'h30 || dig_sel !== 4'b1101) begin
            errors++; $display("FAIL load_tick_next got seg=%h dig=%b exp seg=30 dig=1101", seg, dig_sel);
        end
        scan_mode = 1'b0;
        step();
        checks++;
        if (seg !== 7'h7F || dig_sel !== 4'b1111) begin
            errors++; $display("FAIL scan_exit got seg=%h dig=%b exp seg=7f dig=1111", seg, dig_sel);
        end
    endtask

    initial begin
        test_reset();
        test_load();
        test_blink();
        test_scan();
        test_reset_mid_scan();
        test_load_during_scan();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
